uart_nbyterecv_3bytedata_parser: RTL and testbench
==================================================

Name: uart_NbyteRecv_3byteData_parser

Overview:
- Receive-side counterpart of the team's 3-byte-sample UART frame transmitter.
- Consumes bytes from the UART receiver (one rx_done pulse per byte) and locks onto the frame header 0x45 0x45 0x53 0x53.
- Reassembles each 4-byte sample (low, mid, high, pad 0x00) into a 24-bit word, tracks the FRAME_NUM-sample frame structure, and flags framing errors to downstream logic.

Parameters:
- FRAME_NUM, 1000, samples per frame; one header precedes sample 0 of every frame.
- CNT_W, 11, width of the sample counter; must satisfy 2^CNT_W >= FRAME_NUM.
- TIMEOUT_CYC, 50000, inter-byte gap limit in clk cycles; used only with RX_TIMEOUT_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx_done  input  1  one-cycle pulse; rx_d holds a valid byte in that cycle.
- rx_d  input  8  received byte.
- data  output  24  last assembled sample, {high, mid, low}.
- data_valid  output  1  one-cycle pulse; data is updated in the same cycle.
- sof  output  1  pulse coincident with data_valid of sample 0.
- eof  output  1  pulse coincident with data_valid of sample FRAME_NUM-1.
- locked  output  1  high while header-synchronised.
- sample_cnt  output  CNT_W  index of the next expected sample in the frame.
- err  output  1  one-cycle pulse on any framing error.
- err_cnt  output  8  saturating error count (holds at 255).

Behaviour:
- Reset values:
  - all outputs 0;
  - state H_E1;
  - internal byte registers 0.
- Reset is honoured at any time, including mid-word; the partial word is discarded.
- Only cycles with rx_done=1 advance the FSM (except timeout). rx_d is ignored when rx_done=0.
- All outputs are registered. A byte arriving at cycle N produces data_valid, sof, eof, err and locked changes at cycle N+1.
- Header hunt (locked=0). Each transition below happens on a byte:
  - H_E1: 0x45 -> H_E2; any other byte -> H_E1.
  - H_E2: 0x45 -> H_S1; any other byte -> H_E1.
  - H_S1: 0x53 -> H_S2; 0x45 -> H_S1 (a run of 0x45 keeps the last two as the match); any other byte -> H_E1.
  - H_S2: 0x53 -> B0, locked<=1, sample_cnt<=0; 0x45 -> H_E2; any other byte -> H_E1.
- Data assembly (locked=1):
  - B0: store low byte -> B1.
  - B1: store mid byte -> B2.
  - B2: store high byte -> B3.
  - B3 with pad byte 0x00:
    - data<={hi,mid,lo} and data_valid<=1;
    - sof<=1 if sample_cnt==0;
    - eof<=1 if sample_cnt==FRAME_NUM-1;
    - if sample_cnt==FRAME_NUM-1: sample_cnt<=0, next state R_E1 (header re-check);
    - otherwise sample_cnt<=sample_cnt+1, next state B0.
  - B3 with pad byte != 0x00: no data_valid, err<=1, locked<=0, next state H_E1.
- Header re-check, R_E1 -> R_E2 -> R_S1 -> R_S2 (locked stays 1):
  - each state expects 0x45, 0x45, 0x53, 0x53 in turn;
  - a correct byte advances; R_S2 with 0x53 -> B0;
  - a wrong byte: err<=1, locked<=0, and the FSM re-enters the hunt as if that byte were seen in H_E1 (0x45 -> H_E2, else H_E1).
- Every err pulse increments err_cnt; err_cnt saturates at 255.
- data holds its value between data_valid pulses.
- sample_cnt holds at 0 while unlocked.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - a gap counter clears on every rx_done and increments every other cycle;
  - the counter only matters in states B1, B2, B3, H_E2..H_S2 and R_*;
  - on reaching TIMEOUT_CYC: partial word discarded, err<=1 if locked, locked<=0, state H_E1;
  - rx_done in the same cycle as the timeout: the byte wins and the timer clears.
- Undefined: no gap counter; the FSM waits indefinitely for bytes.

Test Plan:
- FRAME_NUM=3 for all tests. Bytes 45 45 53 53 | 11 22 33 00 | 44 55 66 00 | 77 88 99 00 -> data_valid x3 with data 0x332211, 0x665544, 0x998877; sof on the first pulse, eof on the third; err=0; sample_cnt returns to 0.
- Leading junk 45 45 45 53 53 then one sample AA BB CC 00 -> lock after the 5th byte; data=0xCCBBAA.
- Locked, then word 01 02 03 7F -> no data_valid, err pulse, locked=0, err_cnt=1. Next valid header + sample relocks.
- After 3 samples, next bytes 45 12 ... -> err at the 0x12 byte, locked=0. Then 45 53 53 must not lock; the full 45 45 53 53 does.
- Assert rst after bytes 45 45 53 53 11 22 -> all outputs 0. A following header plus 33 44 55 00 yields 0x554433.
- RX_TIMEOUT_EN, TIMEOUT_CYC=100: a 101-cycle gap after byte B1 -> err, unlocked. A gap of 99 cycles -> normal completion.

Source files
------------

// File: rtl/uart_nbyterecv_3bytedata_parser.sv
// UART byte-stream parser: header lock on 45 45 53 53, 4-byte samples -> 24-bit words.
// Optional inter-byte timeout when RX_TIMEOUT_EN is defined (adds TIMEOUT_CYC).
module uart_nbyterecv_3bytedata_parser #(
    parameter int FRAME_NUM = 1000,
    parameter int CNT_W     = 11
`ifdef RX_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 50000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_done,
    input  logic [7:0]       rx_d,
    output logic [23:0]      data,
    output logic             data_valid,
    output logic             sof,
    output logic             eof,
    output logic             locked,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam logic [3:0] H_E1 = 4'd0;
    localparam logic [3:0] H_E2 = 4'd1;
    localparam logic [3:0] H_S1 = 4'd2;
    localparam logic [3:0] H_S2 = 4'd3;
    localparam logic [3:0] B0   = 4'd4;
    localparam logic [3:0] B1   = 4'd5;
    localparam logic [3:0] B2   = 4'd6;
    localparam logic [3:0] B3   = 4'd7;
    localparam logic [3:0] R_E1 = 4'd8;
    localparam logic [3:0] R_E2 = 4'd9;
    localparam logic [3:0] R_S1 = 4'd10;
    localparam logic [3:0] R_S2 = 4'd11;

    localparam logic [7:0]       CH_E = 8'h45;
    localparam logic [7:0]       CH_S = 8'h53;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_NUM - 1);

    logic [3:0]       state_q, state_d;
    logic [7:0]       lo_q, lo_d, mid_q, mid_d, hi_q, hi_d;
    logic [23:0]      data_q, data_d;
    logic             dv_q, dv_d, sof_q, sof_d, eof_q, eof_d;
    logic             err_q, err_d, locked_q, locked_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       errcnt_q, errcnt_d;
    logic             tmo;

`ifdef RX_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYC + 1);
    logic [GW-1:0] gap_q, gap_d;

    always_comb begin
        gap_d = gap_q;
        if (rx_done)
            gap_d = '0;
        else if (gap_q != GW'(TIMEOUT_CYC))
            gap_d = gap_q + 1'b1;
    end

    // B0 and H_E1 are idle points where waiting forever is legal
    assign tmo = !rx_done && (gap_q == GW'(TIMEOUT_CYC)) &&
                 (state_q inside {B1, B2, B3, H_E2, H_S1, H_S2,
                                  R_E1, R_E2, R_S1, R_S2});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) gap_q <= '0;
        else     gap_q <= gap_d;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        mid_d    = mid_q;
        hi_d     = hi_q;
        data_d   = data_q;
        dv_d     = 1'b0;
        sof_d    = 1'b0;
        eof_d    = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        if (rx_done) begin
            unique case (state_q)
                H_E1: state_d = (rx_d == CH_E) ? H_E2 : H_E1;
                H_E2: state_d = (rx_d == CH_E) ? H_S1 : H_E1;
                H_S1: begin
                    if (rx_d == CH_S)      state_d = H_S2;
                    else if (rx_d == CH_E) state_d = H_S1;
                    else                   state_d = H_E1;
                end
                H_S2: begin
                    if (rx_d == CH_S) begin
                        state_d  = B0;
                        locked_d = 1'b1;
                        cnt_d    = '0;
                    end else if (rx_d == CH_E) begin
                        state_d = H_E2;
                    end else begin
                        state_d = H_E1;
                    end
                end
                B0: begin lo_d  = rx_d; state_d = B1; end
                B1: begin mid_d = rx_d; state_d = B2; end
                B2: begin hi_d  = rx_d; state_d = B3; end
                B3: begin
                    if (rx_d == 8'h00) begin
                        data_d = {hi_q, mid_q, lo_q};
                        dv_d   = 1'b1;
                        sof_d  = (cnt_q == '0);
                        eof_d  = (cnt_q == LAST);
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = R_E1;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = B0;
                        end
                    end else begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = H_E1;
                    end
                end
                R_E1, R_E2, R_S1, R_S2: begin
                    if ((state_q == R_E1 && rx_d == CH_E) ||
                        (state_q == R_E2 && rx_d == CH_E) ||
                        (state_q == R_S1 && rx_d == CH_S)) begin
                        state_d = state_q + 4'd1;
                    end else if (state_q == R_S2 && rx_d == CH_S) begin
                        state_d = B0;
                    end else begin
                        // failed re-check byte is reused as the first hunt byte
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = (rx_d == CH_E) ? H_E2 : H_E1;
                    end
                end
                default: state_d = H_E1;
            endcase
        end else if (tmo) begin
            err_d    = locked_q;
            locked_d = 1'b0;
            cnt_d    = '0;
            state_d  = H_E1;
        end
        errcnt_d = errcnt_q;
        if (err_d && errcnt_q != 8'hFF)
            errcnt_d = errcnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= H_E1;
            lo_q     <= '0;
            mid_q    <= '0;
            hi_q     <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            mid_q    <= mid_d;
            hi_q     <= hi_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign sof        = sof_q;
    assign eof        = eof_q;
    assign locked     = locked_q;
    assign sample_cnt = cnt_q;
    assign err        = err_q;
    assign err_cnt    = errcnt_q;

endmodule

// File: tb/tb_uart_nbyterecv_3bytedata_parser.sv
// Directed bench for the 3-byte-sample frame parser, FRAME_NUM=3.
module tb_uart_nbyterecv_3bytedata_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_done;
    logic [7:0]  rx_d;
    logic [23:0] data;
    logic        data_valid, sof, eof, locked, err;
    logic [1:0]  sample_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    logic err_acc;
    int   dv_acc;

    always #5 clk = ~clk;

    uart_nbyterecv_3bytedata_parser #(
        .FRAME_NUM(3),
        .CNT_W(2)
`ifdef RX_TIMEOUT_EN
        , .TIMEOUT_CYC(100)
`endif
    ) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_d(rx_d),
        .data(data), .data_valid(data_valid), .sof(sof), .eof(eof),
        .locked(locked), .sample_cnt(sample_cnt), .err(err),
        .err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // outputs for the byte are visible when this returns
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_done = 1'b1;
        rx_d    = b;
        @(negedge clk);
        rx_done = 1'b0;
        rx_d    = 8'hxx;
        err_acc = err_acc | err;
        if (data_valid) dv_acc++;
    endtask

    task automatic header();
        send(8'h45); send(8'h45); send(8'h53); send(8'h53);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, {8'h0, data}, 32'h0);
        chk({tag, "_ctl"}, {26'h0, data_valid, sof, eof, locked, err, 1'b0}, 32'h0);
        chk({tag, "_cnt"}, {30'h0, sample_cnt}, 32'h0);
        chk({tag, "_ecnt"}, {24'h0, err_cnt}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; rx_done = 1'b0; rx_d = 8'h00;
        err_acc = 1'b0; dv_acc = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // basic frame of three samples
        send(8'h45); send(8'h45); send(8'h53);
        chk("pre_lock", {31'h0, locked}, 32'h0);
        send(8'h53);
        chk("lock", {31'h0, locked}, 32'h1);
        chk("lock_cnt", {30'h0, sample_cnt}, 32'h0);
        send(8'h11); send(8'h22); send(8'h33); send(8'h00);
        chk("s0_data", {8'h0, data}, 32'h332211);
        chk("s0_flags", {29'h0, data_valid, sof, eof}, 32'b110);
        chk("s0_cnt", {30'h0, sample_cnt}, 32'h1);
        send(8'h44); send(8'h55); send(8'h66);
        chk("hold", {8'h0, data}, 32'h332211);
        chk("nodv", {31'h0, data_valid}, 32'h0);
        send(8'h00);
        chk("s1_data", {8'h0, data}, 32'h665544);
        chk("s1_flags", {29'h0, data_valid, sof, eof}, 32'b100);
        send(8'h77); send(8'h88); send(8'h99); send(8'h00);
        chk("s2_data", {8'h0, data}, 32'h998877);
        chk("s2_flags", {29'h0, data_valid, sof, eof}, 32'b101);
        chk("s2_cnt", {30'h0, sample_cnt}, 32'h0);
        chk("frame_err", {31'h0, err_acc}, 32'h0);
        chk("frame_dv", dv_acc, 32'd3);

        // bad header re-check byte
        send(8'h45);
        chk("rchk_ok", {30'h0, locked, err}, 32'b10);
        send(8'h12);
        chk("rchk_bad", {30'h0, locked, err}, 32'b01);
        chk("rchk_ecnt", {24'h0, err_cnt}, 32'h1);
        send(8'h45); send(8'h53); send(8'h53);
        chk("short_hdr", {31'h0, locked}, 32'h0);
        header();
        chk("relock", {31'h0, locked}, 32'h1);

        // bad pad byte
        dv_acc = 0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h7F);
        chk("pad_bad", {29'h0, data_valid, locked, err}, 32'b001);
        chk("pad_dv", dv_acc, 32'd0);
        chk("pad_ecnt", {24'h0, err_cnt}, 32'h2);

        // leading junk 0x45 run
        send(8'h45); send(8'h45); send(8'h45); send(8'h53);
        chk("junk4", {31'h0, locked}, 32'h0);
        send(8'h53);
        chk("junk5", {31'h0, locked}, 32'h1);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'h00);
        chk("junk_data", {8'h0, data}, 32'hCCBBAA);
        chk("junk_sof", {30'h0, data_valid, sof}, 32'b11);

        // error counter saturation
        for (int i = 0; i < 260; i++) begin
            send(8'h00); send(8'h00); send(8'h01);
            header();
            send(8'h00); send(8'h00); send(8'h00); send(8'h01);
        end
        chk("sat_ecnt", {24'h0, err_cnt}, 32'hFF);
        chk("sat_err", {31'h0, err}, 32'h1);

        // reset mid-word
        header();
        send(8'h11); send(8'h22);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        header();
        send(8'h33); send(8'h44); send(8'h55); send(8'h00);
        chk("post_rst_data", {8'h0, data}, 32'h554433);
        chk("post_rst_flags", {29'h0, data_valid, sof, eof}, 32'b110);
        chk("post_rst_cnt", {30'h0, sample_cnt}, 32'h1);

`ifdef RX_TIMEOUT_EN
        // long gap inside a word
        send(8'h01);
        repeat (150) @(negedge clk);
        chk("tmo_lock", {31'h0, locked}, 32'h0);
        chk("tmo_ecnt", {24'h0, err_cnt}, 32'h1);
        header();
        send(8'h01);
        repeat (98) @(negedge clk);
        send(8'h02); send(8'h03); send(8'h00);
        chk("gap99_data", {8'h0, data}, 32'h030201);
        chk("gap99_lock", {30'h0, locked, data_valid}, 32'b11);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
